// File: rtl/data_bus_bridge_pkg.sv
// Shared encodings for the data-bus bridge: request types, access sizes, byte enables
// and the alignment rule applied when a request is accepted.
package data_bus_bridge_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_NONE = 2'd0,
    MEM_ACCESS_R    = 2'd1,
    MEM_ACCESS_W    = 2'd2,
    MEM_ACCESS_X    = 2'd3
  } mem_access_t;

  typedef enum logic [1:0] {
    MEM_LEN_BYTE = 2'd0,
    MEM_LEN_HALF = 2'd1,
    MEM_LEN_WORD = 2'd2
  } mem_len_t;

  typedef logic [3:0] mem_be_t;

  function automatic logic misaligned(input mem_len_t len, input logic [1:0] lo);
    case (len)
      MEM_LEN_BYTE: return 1'b0;
      MEM_LEN_HALF: return lo[0];
      default:      return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_bridge_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for writes,
// lane extraction with zero/sign extension for reads.
module bus_lane_align
  import data_bus_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  mem_len_t    len_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output mem_be_t     be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_field;
  logic [15:0] half_field;

  assign byte_field = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_field = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (len_i)
      MEM_LEN_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_field[7]}}, byte_field};
      end
      MEM_LEN_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & half_field[15]}}, half_field};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_bus_bridge.sv
// Bridges single-outstanding bus requests onto a fixed-latency synchronous SRAM,
// with alignment/range faulting at acceptance and a one-cycle ready pulse.
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wdata,
  input  mem_access_t           bus_accessType,
  input  mem_len_t              bus_memLen,
  input  logic                  bus_signed,
  output logic [31:0]           bus_rdata,
  output logic                  bus_ready,
  output logic                  bus_fault,
  output logic                  mem_en,
  output logic                  mem_we,
  output mem_be_t               mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            lo_q, lo_d;
  mem_len_t              len_q, len_d;
  logic                  sgn_q, sgn_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  en_q, en_d, we_q, we_d;
  mem_be_t               be_q, be_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [31:0]           mwdata_q, mwdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d, fault_q, fault_d;

  logic        idle, req, acc_fault;
  mem_len_t    eff_len, al_len;
  logic [1:0]  al_lo;
  logic        al_sgn;
  mem_be_t     al_be;
  logic [31:0] al_wdata, al_rdata;

  // The aligner sees the live request while idle (store steering) and the
  // latched request afterwards (load extraction).
  assign idle      = (state_q == S_IDLE);
  assign req       = (bus_accessType != MEM_ACCESS_NONE);
  assign eff_len   = (bus_accessType == MEM_ACCESS_X) ? MEM_LEN_WORD : bus_memLen;
  assign acc_fault = misaligned(eff_len, bus_addr[1:0]) ||
                     (bus_addr[31:ADDR_WIDTH+2] != '0);
  assign al_lo     = idle ? bus_addr[1:0] : lo_q;
  assign al_len    = idle ? eff_len : len_q;
  assign al_sgn    = idle ? bus_signed : sgn_q;

  bus_lane_align u_align (
    .addr_lo_i (al_lo),
    .len_i     (al_len),
    .signed_i  (al_sgn),
    .wdata_i   (bus_wdata),
    .rdata_i   (mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      len_q    <= MEM_LEN_BYTE;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      len_q    <= len_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      be_q     <= be_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    len_d    = len_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    be_d     = be_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lo_d  = bus_addr[1:0];
          len_d = eff_len;
          sgn_d = bus_signed;
          if (acc_fault) begin
            state_d = S_DONE;
            ready_d = 1'b1;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            // SRAM strobes are registered here so they are valid for the whole ISSUE cycle.
            state_d  = S_ISSUE;
            en_d     = 1'b1;
            we_d     = (bus_accessType == MEM_ACCESS_W);
            be_d     = (bus_accessType == MEM_ACCESS_W) ? al_be : 4'b1111;
            maddr_d  = bus_addr[ADDR_WIDTH+1:2];
            mwdata_d = al_wdata;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = 3'(RD_LATENCY);
        if (we_q) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          rdata_d = al_rdata;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign bus_fault = fault_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;

endmodule

// File: doc/data_bus_bridge.md
DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter: ADDR_WIDTH, 14, word-address bits of the attached SRAM (capacity 4*2^ADDR_WIDTH bytes).
REQ-002 Parameter: RD_LATENCY, 1, cycles from SRAM read enable to valid mem_rdata (legal 1..7).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high; ports are clk and res.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 res  in  1  asynchronous active-high reset.
REQ-006 bus_addr  in  32  physical byte address from the MMU stage.
REQ-007 bus_wdata  in  32  store data, right-aligned.
REQ-008 bus_accessType  in  `MEM_ACCESS_T  request type: NONE/R/W/X.
REQ-009 bus_memLen  in  `MEM_LEN  access size: byte/half/word.
REQ-010 bus_signed  in  1  sign-extend sub-word loads.
REQ-011 bus_rdata  out  32  load data, aligned and extended.
REQ-012 bus_ready  out  1  one-cycle completion pulse.
REQ-013 bus_fault  out  1  completion was a fault (valid with bus_ready).
REQ-014 mem_en  out  1  SRAM access enable.
REQ-015 mem_we  out  1  SRAM write enable.
REQ-016 mem_be  out  4  byte enables, bit i = bits 8i+7:8i.
REQ-017 mem_addr  out  ADDR_WIDTH  SRAM word address (bus_addr[ADDR_WIDTH+1:2]).
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rdata  in  32  SRAM read word.

Function
REQ-020 FSM states: S_IDLE, S_ISSUE, S_WAIT, S_DONE; all SRAM-side outputs registered.
REQ-021 S_IDLE: request = accessType in {R, W, X}; on request, latch addr/len/signed/wdata/type, go S_ISSUE; else stay.
REQ-022 Fault check at acceptance: half with addr[0]=1, word or X with addr[1:0]!=0, or addr[31:ADDR_WIDTH+2]!=0 -> go S_DONE directly, bus_fault=1, bus_rdata=0, no SRAM cycle.
REQ-023 X is a word read; bus_memLen and bus_signed are ignored for X.
REQ-024 S_ISSUE lasts exactly one cycle with mem_en=1, mem_we=1 for W else 0.
REQ-025 Write lanes: byte -> wdata[7:0] replicated x4, be=1<<addr[1:0]; half -> wdata[15:0] replicated x2, be=0011 (addr[1]=0) or 1100; word -> wdata, be=1111; little-endian.
REQ-026 Reads drive mem_be=1111; W goes S_ISSUE -> S_DONE.
REQ-027 R/X go S_ISSUE -> S_WAIT; 3-bit counter loaded with RD_LATENCY in S_ISSUE, decremented each S_WAIT cycle; on the S_WAIT cycle with count=1, mem_rdata is captured, go S_DONE.
REQ-028 Read extraction: byte lane addr[1:0], half lane addr[1]; zero-extend unless signed=1, then replicate MSB of the extracted field.
REQ-029 S_DONE: bus_ready=1 for exactly one cycle, then S_IDLE; request inputs ignored in S_DONE (upstream still holds them).
REQ-030 Latency: W ready 2 cycles after acceptance edge; R/X ready RD_LATENCY+2 cycles after acceptance edge; fault ready 1 cycle after.
REQ-031 bus_rdata holds its last value until the next read or fault completion; writes do not change it.
REQ-032 bus_fault is 0 whenever bus_ready=0.
REQ-033 Inputs changing after acceptance have no effect on the in-flight access.

Reset
REQ-034 res asserted: state=S_IDLE, bus_ready=0, bus_fault=0, bus_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0, immediately and asynchronously.
REQ-035 res mid-access aborts it: no bus_ready pulse issued; a write in S_ISSUE may or may not commit.

Structure
REQ-036 MEM_ACCESS_*, MEM_LEN_* encodings stay in DataBus.vh; add `MEM_BE_T (4-bit) there; state localparams stay local.
REQ-037 One combinational sub-module bus_lane_align: (addr[1:0], len, signed, wdata, rdata) -> (be, repl wdata, extended rdata).

Verification
REQ-038 W byte addr=0x0000_0006 wdata=0x0000_00A5 -> S_ISSUE mem_be=0100, mem_wdata=0xA5A5_A5A5, mem_addr=1; ready 2 cycles later, fault=0.
REQ-039 R half signed addr=0x2, SRAM word 0x8001_1234, RD_LATENCY=1 -> bus_rdata=0xFFFF_8001, ready at +3; unsigned -> 0x0000_8001.
REQ-040 R word addr=0x1 -> ready at +1, bus_fault=1, bus_rdata=0, mem_en never 1.
REQ-041 X addr beyond 4*2^ADDR_WIDTH -> fault; RD_LATENCY=3 read -> ready at +5.
REQ-042 Request held through S_DONE then dropped -> exactly one SRAM access, one ready pulse; res in S_WAIT -> all outputs 0 at once, no ready.
